ahb_master_if: RTL and testbench
================================

Name: ahb_master_if

Overview:
- Upstream neighbour of the bus arbiter: converts one simple core-side request into a single AHB-Lite/AHB2 transfer.
- Drives HBUSREQ and HLOCK to the arbiter and waits for HGRANT.
- Issues a NONSEQ SINGLE transfer and handles wait states plus the ERROR, RETRY and SPLIT responses.
- Returns read data and status to the core with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RETRY_MAX, 15, maximum RETRY/SPLIT re-issues before the request completes with an error (4-bit counter).

Ports:
- HCLK  in  1  bus clock; everything in the block is clocked on its rising edge.
- HRESETn  in  1  synchronous, active-low reset, sampled on the HCLK rising edge.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address.
- req_size  in  3  HSIZE encoding of the transfer.
- req_wdata  in  DATA_W  write data.
- req_lock  in  1  request a locked transfer.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data, valid with resp_valid.
- resp_err  out  1  ERROR response or retry limit exhausted.
- HBUSREQ  out  1  bus request to the arbiter.
- HLOCK  out  1  lock request to the arbiter.
- HGRANT  in  1  grant from the arbiter.
- HREADY  in  1  bus ready.
- HRESP  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
- HRDATA  in  DATA_W  read data bus.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HADDR  out  ADDR_W  address bus.
- HWRITE  out  1  write strobe.
- HSIZE  out  3  transfer size.
- HBURST  out  3  constant SINGLE (000).
- HPROT  out  4  constant 4'b0011.
- HWDATA  out  DATA_W  write data bus.

Behaviour:
- Reset (HRESETn low at a rising edge):
  - State = IDLE.
  - req_ready=1; HBUSREQ, HLOCK, resp_valid, resp_err = 0.
  - HTRANS=IDLE; HADDR, HWDATA, resp_rdata and the retry counter = 0.
  - Reset mid-transfer drops the transfer silently; no resp_valid is produced.
- Acceptance:
  - req_ready=1 only in IDLE.
  - On req_valid&&req_ready the block registers addr, write, size, wdata and lock, then goes to REQ.
  - Registered fields stay stable until the transfer completes.
- States:
  - IDLE: HTRANS=IDLE, HBUSREQ=0.
  - REQ: HBUSREQ=1, HLOCK=lock, HTRANS=IDLE. At a rising edge with HGRANT&&HREADY, go to ADDR.
  - ADDR: HTRANS=NONSEQ; HADDR, HWRITE, HSIZE from the registered request; HBUSREQ=1, HLOCK=lock. Hold while HREADY=0; on HREADY=1 go to DATA. Loss of HGRANT during ADDR is ignored, because ownership was already sampled.
  - DATA:
    - Outputs: HTRANS=IDLE, HBUSREQ=0, HLOCK=0; HWDATA=wdata on a write, 0 on a read.
    - HREADY=1: transfer complete. Next cycle resp_valid=1, resp_rdata=HRDATA (read) or 0 (write), resp_err=(HRESP==ERROR). Return to IDLE and clear the retry counter.
    - HREADY=0 with HRESP=RETRY or SPLIT: go to RETRY_IDLE.
    - HREADY=0 with HRESP=OKAY or ERROR: hold.
  - RETRY_IDLE:
    - Outputs: HTRANS=IDLE, HBUSREQ=0; HWDATA held.
    - On HREADY=1 (second response cycle): if counter==RETRY_MAX, complete with resp_err=1 and go to IDLE; otherwise increment the counter and go to REQ to re-issue the identical transfer.
- Latency:
  - With HGRANT and HREADY constantly high, and the request accepted at edge 0: REQ in cycle 1, ADDR in cycle 2, DATA in cycle 3, resp_valid in cycle 4.
  - Each wait state adds 1 cycle.
- Outputs are registered or derived from the state register only; there is no combinational path from HRDATA or HRESP to AHB outputs.
- Only one transfer is outstanding at a time; there is no pipelining of consecutive requests.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS, HRESP, HBURST and HSIZE encodings;
  - the HPROT default;
  - typedef enum for the states {IDLE, REQ, ADDR, DATA, RETRY_IDLE};
  - a request struct {addr, wdata, size, write, lock}.
- No sub-module: the FSM and the retry counter live in one module.

Test Plan:
- Zero-wait read of 0x0000_1000 with HGRANT=1, HRDATA=0xDEADBEEF -> HTRANS=NONSEQ for exactly 1 cycle with HADDR=0x1000 and HWRITE=0; resp_valid 4 cycles after accept; rdata=0xDEADBEEF; err=0.
- Write 0x12345678 to 0x2004 with HREADY low 2 cycles in the data phase -> HWDATA=0x12345678 held for 3 cycles; resp_valid the cycle after HREADY returns; err=0.
- HGRANT low for 5 cycles after accept -> HBUSREQ=1 and HTRANS=IDLE throughout; NONSEQ the cycle after HGRANT rises; req_ready=0 until resp.
- Single RETRY (HREADY=0/RETRY, then HREADY=1/RETRY) -> 1+ IDLE cycles; HBUSREQ re-asserted; NONSEQ re-issued to the same address; final OKAY gives err=0.
- ERROR two-cycle response -> resp_valid=1, resp_err=1; locked request shows HLOCK=1 in REQ/ADDR and 0 afterwards.
- Repeated RETRY with RETRY_MAX=2 -> exactly 3 NONSEQ issues then resp_err=1; separately, HRESETn low during ADDR -> next cycle HTRANS=IDLE, HBUSREQ=0, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and the registered core request.
package ahb_pkg;

    localparam int unsigned AHB_ADDR_W = 32;
    localparam int unsigned AHB_DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA,
        ST_RETRY_IDLE
    } state_e;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
        logic [2:0]            size;
        logic                  write;
        logic                  lock;
    } req_t;

    function automatic logic is_retry_resp(input logic [1:0] resp);
        return (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
    endfunction

endpackage

// File: rtl/ahb_master_if.sv
// Single-transfer AHB master: turns one core request into a NONSEQ SINGLE
// transfer, handling arbitration, wait states and ERROR/RETRY/SPLIT responses.
module ahb_master_if
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W    = AHB_ADDR_W,
    parameter int unsigned DATA_W    = AHB_DATA_W,
    parameter int unsigned RETRY_MAX = 15
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_lock,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              HBUSREQ,
    output logic              HLOCK,
    input  logic              HGRANT,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [1:0]        HTRANS,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA
);

    state_e            r_state;
    req_t              r_req;
    logic [3:0]        r_retry_cnt;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              r_hbusreq;
    logic              r_hlock;
    logic [1:0]        r_htrans;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [DATA_W-1:0] r_hwdata;

    logic              w_retry_limit;
    assign w_retry_limit = (r_retry_cnt == 4'(RETRY_MAX));

    // Every output is registered and loaded on the transition into the state that owns it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_retry_cnt  <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_hbusreq    <= 1'b0;
            r_hlock      <= 1'b0;
            r_htrans     <= HTRANS_IDLE;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hsize      <= '0;
            r_hwdata     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req.addr  <= AHB_ADDR_W'(req_addr);
                        r_req.wdata <= AHB_DATA_W'(req_wdata);
                        r_req.size  <= req_size;
                        r_req.write <= req_write;
                        r_req.lock  <= req_lock;
                        r_req_ready <= 1'b0;
                        r_hbusreq   <= 1'b1;
                        r_hlock     <= req_lock;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (HGRANT && HREADY) begin
                        r_htrans <= HTRANS_NONSEQ;
                        r_haddr  <= ADDR_W'(r_req.addr);
                        r_hwrite <= r_req.write;
                        r_hsize  <= r_req.size;
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_htrans  <= HTRANS_IDLE;
                        r_hbusreq <= 1'b0;
                        r_hlock   <= 1'b0;
                        r_hwdata  <= r_req.write ? DATA_W'(r_req.wdata) : '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= (HRESP == HRESP_ERROR);
                        r_resp_rdata <= r_req.write ? '0 : HRDATA;
                        r_retry_cnt  <= '0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (is_retry_resp(HRESP)) begin
                        r_state <= ST_RETRY_IDLE;
                    end
                end
                ST_RETRY_IDLE: begin
                    if (HREADY) begin
                        if (w_retry_limit) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_retry_cnt  <= '0;
                            r_req_ready  <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                            r_hbusreq   <= 1'b1;
                            r_hlock     <= r_req.lock;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign HBUSREQ    = r_hbusreq;
    assign HLOCK      = r_hlock;
    assign HTRANS     = r_htrans;
    assign HADDR      = r_haddr;
    assign HWRITE     = r_hwrite;
    assign HSIZE      = r_hsize;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_DEFAULT;
    assign HWDATA     = r_hwdata;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if; responses are checked by a scoreboard
// monitor that pops expected entries whenever resp_valid is seen.
module tb_ahb_master_if;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [2:0]        req_size = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_lock = 1'b0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              HBUSREQ;
    logic              HLOCK;
    logic              HGRANT = 1'b1;
    logic              HREADY = 1'b1;
    logic [1:0]        HRESP = 2'b00;
    logic [DATA_W-1:0] HRDATA = '0;
    logic [1:0]        HTRANS;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;

    ahb_master_if #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RETRY_MAX (2)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_lock   (req_lock),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .HBUSREQ    (HBUSREQ),
        .HLOCK      (HLOCK),
        .HGRANT     (HGRANT),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .HTRANS     (HTRANS),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HWDATA     (HWDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int unsigned       cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned resp_cnt = 0;
    int unsigned nonseq_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        exp_t e;
        if (HTRANS == 2'b10) nonseq_cnt++;
        if (resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                chk("resp_err", 64'(resp_err), 64'(e.err));
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Presents one request and returns the cycle index of its accepting edge.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [2:0] size,
                         input logic [DATA_W-1:0] wdata, input logic lock,
                         output int unsigned acc);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        req_lock  = lock;
        step();
        acc = cyc;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        chk("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    task automatic expect_resp(input logic [DATA_W-1:0] rdata, input logic err, input int unsigned at);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_resp(input int unsigned target);
        int unsigned i = 0;
        while (resp_cnt < target && i < 60) begin
            step();
            i++;
        end
        if (resp_cnt < target) chk("resp_timeout", 64'(resp_cnt), 64'(target));
        step();
    endtask

    initial begin
        int unsigned acc;
        int unsigned ns0;
        int unsigned tgt;

        // Reset state
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_hbusreq", 64'(HBUSREQ), 64'd0);
        chk("rst_hlock", 64'(HLOCK), 64'd0);
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwdata", 64'(HWDATA), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("hburst", 64'(HBURST), 64'd0);
        chk("hprot", 64'(HPROT), 64'h3);
        HRESETn = 1'b1;
        step();

        // Zero-wait read
        HRDATA = 32'hDEAD_BEEF;
        ns0 = nonseq_cnt;
        tgt = resp_cnt + 1;
        issue(1'b0, 32'h0000_1000, 3'b010, 32'h0, 1'b0, acc);
        expect_resp(32'hDEAD_BEEF, 1'b0, acc + 3);
        chk("t1_req_hbusreq", 64'(HBUSREQ), 64'd1);
        chk("t1_req_htrans", 64'(HTRANS), 64'd0);
        step();
        chk("t1_addr_htrans", 64'(HTRANS), 64'h2);
        chk("t1_addr_haddr", 64'(HADDR), 64'h1000);
        chk("t1_addr_hwrite", 64'(HWRITE), 64'd0);
        chk("t1_addr_hsize", 64'(HSIZE), 64'h2);
        wait_resp(tgt);
        chk("t1_nonseq_cycles", 64'(nonseq_cnt - ns0), 64'd1);

        // Write with two data-phase wait states
        tgt = resp_cnt + 1;
        issue(1'b1, 32'h0000_2004, 3'b010, 32'h1234_5678, 1'b0, acc);
        expect_resp(32'h0, 1'b0, acc + 5);
        step();
        chk("t2_addr_haddr", 64'(HADDR), 64'h2004);
        chk("t2_addr_hwrite", 64'(HWRITE), 64'd1);
        step();
        HREADY = 1'b0;
        chk("t2_hwdata_0", 64'(HWDATA), 64'h1234_5678);
        step();
        chk("t2_hwdata_1", 64'(HWDATA), 64'h1234_5678);
        step();
        chk("t2_hwdata_2", 64'(HWDATA), 64'h1234_5678);
        HREADY = 1'b1;
        wait_resp(tgt);

        // Grant withheld for five cycles
        HRDATA = 32'hCAFE_F00D;
        HGRANT = 1'b0;
        tgt = resp_cnt + 1;
        issue(1'b0, 32'h0000_3000, 3'b010, 32'h0, 1'b0, acc);
        expect_resp(32'hCAFE_F00D, 1'b0, acc + 7);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hbusreq", 64'(HBUSREQ), 64'd1);
            chk("t3_htrans_idle", 64'(HTRANS), 64'd0);
            chk("t3_req_ready", 64'(req_ready), 64'd0);
            if (i == 4) HGRANT = 1'b1;
            step();
        end
        chk("t3_nonseq_after_grant", 64'(HTRANS), 64'h2);
        wait_resp(tgt);

        // Single RETRY then OKAY
        HRDATA = 32'h0BAD_F00D;
        ns0 = nonseq_cnt;
        tgt = resp_cnt + 1;
        issue(1'b0, 32'h0000_4000, 3'b010, 32'h0, 1'b0, acc);
        expect_resp(32'h0BAD_F00D, 1'b0, acc + 7);
        step();
        step();
        HREADY = 1'b0;
        HRESP  = 2'b10;
        step();
        HREADY = 1'b1;
        chk("t4_retry_htrans", 64'(HTRANS), 64'd0);
        chk("t4_retry_hbusreq", 64'(HBUSREQ), 64'd0);
        step();
        HRESP = 2'b00;
        chk("t4_rereq_hbusreq", 64'(HBUSREQ), 64'd1);
        step();
        chk("t4_reissue_htrans", 64'(HTRANS), 64'h2);
        chk("t4_reissue_haddr", 64'(HADDR), 64'h4000);
        wait_resp(tgt);
        chk("t4_nonseq_issues", 64'(nonseq_cnt - ns0), 64'd2);

        // Locked write with a two-cycle ERROR response
        tgt = resp_cnt + 1;
        issue(1'b1, 32'h0000_5000, 3'b010, 32'hA5A5_A5A5, 1'b1, acc);
        expect_resp(32'h0, 1'b1, acc + 4);
        chk("t5_req_hlock", 64'(HLOCK), 64'd1);
        step();
        chk("t5_addr_hlock", 64'(HLOCK), 64'd1);
        step();
        chk("t5_data_hlock", 64'(HLOCK), 64'd0);
        HREADY = 1'b0;
        HRESP  = 2'b01;
        step();
        HREADY = 1'b1;
        wait_resp(tgt);
        HRESP = 2'b00;
        chk("t5_idle_hlock", 64'(HLOCK), 64'd0);

        // Repeated RETRY exhausting the limit of 2
        ns0 = nonseq_cnt;
        tgt = resp_cnt + 1;
        issue(1'b0, 32'h0000_6000, 3'b010, 32'h0, 1'b0, acc);
        expect_resp(32'h0, 1'b1, acc + 12);
        for (int k = 0; k < 3; k++) begin
            step();
            HRESP = 2'b00;
            step();
            HREADY = 1'b0;
            HRESP  = 2'b10;
            step();
            HREADY = 1'b1;
            step();
        end
        HRESP = 2'b00;
        wait_resp(tgt);
        chk("t6_nonseq_issues", 64'(nonseq_cnt - ns0), 64'd3);

        // Reset during the address phase drops the transfer
        issue(1'b0, 32'h0000_7000, 3'b010, 32'h0, 1'b0, acc);
        step();
        chk("t7_addr_htrans", 64'(HTRANS), 64'h2);
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        chk("t7_rst_htrans", 64'(HTRANS), 64'd0);
        chk("t7_rst_hbusreq", 64'(HBUSREQ), 64'd0);
        chk("t7_rst_req_ready", 64'(req_ready), 64'd1);
        chk("t7_rst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (6) step();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
